// File: rtl/beat_rate_calc_if.sv
// ============================================================================
// Module      : beat_rate_calc_if
// Description : Peak/tick inputs and BPM/BCD result outputs of beat_rate_calc.
//               The outlier counter member is present only when the
//               BEAT_RATE_OUTLIER_EN macro is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface beat_rate_calc_if;
  logic       i_sample_tick;
  logic       i_peak;
  logic [7:0] o_bpm;
  logic [3:0] o_bcd_hund;
  logic [3:0] o_bcd_tens;
  logic [3:0] o_bcd_ones;
  logic       o_valid;
  logic       o_update;
  logic       o_timeout;
`ifdef BEAT_RATE_OUTLIER_EN
  logic [7:0] o_outlier_cnt;
`endif

  modport master (
    output i_sample_tick,
    output i_peak,
`ifdef BEAT_RATE_OUTLIER_EN
    input  o_outlier_cnt,
`endif
    input  o_bpm,
    input  o_bcd_hund,
    input  o_bcd_tens,
    input  o_bcd_ones,
    input  o_valid,
    input  o_update,
    input  o_timeout
  );

  modport slave (
    input  i_sample_tick,
    input  i_peak,
`ifdef BEAT_RATE_OUTLIER_EN
    output o_outlier_cnt,
`endif
    output o_bpm,
    output o_bcd_hund,
    output o_bcd_tens,
    output o_bcd_ones,
    output o_valid,
    output o_update,
    output o_timeout
  );
endinterface

`default_nettype wire

// File: rtl/beat_rate_calc.sv
// ============================================================================
// Module      : beat_rate_calc
// Description : Measures peak-to-peak intervals in sample ticks, averages the
//               last NBEATS of them and reports BPM in binary and BCD, with
//               loss-of-signal detection. Optional macro BEAT_RATE_OUTLIER_EN
//               rejects intervals far from the running average.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module beat_rate_calc #(
  parameter int SAMPLE_HZ    = 1000,
  parameter int NBEATS       = 4,
  parameter int MIN_INTERVAL = 250,
  parameter int MAX_INTERVAL = 3000,
  parameter int DIV_W        = 24
) (
  input  logic             clk,
  input  logic             reset,
  beat_rate_calc_if.slave  bus
);

  localparam int C_LOG2_NB = $clog2(NBEATS);
  localparam int C_FILL_W  = $clog2(NBEATS + 1);
  localparam int C_STEP_W  = (DIV_W > 8) ? $clog2(DIV_W) : 3;
  localparam logic [DIV_W-1:0]    C_DIVIDEND = DIV_W'(60 * SAMPLE_HZ * NBEATS);
  localparam logic [15:0]         C_MIN      = 16'(MIN_INTERVAL);
  localparam logic [15:0]         C_MAX      = 16'(MAX_INTERVAL);
  localparam logic [C_FILL_W-1:0] C_FULL     = C_FILL_W'(NBEATS);
  localparam logic [C_FILL_W-1:0] C_FULL_M1  = C_FILL_W'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_BCD, S_OUT} state_t;

  state_t                r_state, w_next;
  logic                  r_peak_q, r_prior, r_pend;
  logic [15:0]           r_cnt;
  logic [15:0]           r_hist [NBEATS];
  logic [C_LOG2_NB-1:0]  r_wr;
  logic [DIV_W-1:0]      r_sum;
  logic [C_FILL_W-1:0]   r_fill;
  logic [DIV_W-1:0]      r_rem, r_quo, r_den;
  logic [C_STEP_W-1:0]   r_step;
  logic [7:0]            r_q, r_bin;
  logic [11:0]           r_bcd;

  logic w_edge, w_at_max, w_rearm, w_short, w_cand, w_full, w_outlier;
  logic w_accept, w_tmo, w_fill_nx_full, w_start, w_div_last, w_bcd_last, w_ge;
  logic [15:0]      w_evict;
  logic [DIV_W:0]   w_rem_sh;
  logic [DIV_W-1:0] w_sub, w_rem_nx, w_quo_nx;
  logic [7:0]       w_q_sat;
  logic [11:0]      w_adj;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Edge classification: re-arm, refractory ignore, candidate interval, timeout
  always_comb begin
    w_edge         = bus.i_peak & ~r_peak_q;
    w_at_max       = (r_cnt == C_MAX);
    w_rearm        = w_edge & (w_at_max | ~r_prior);
    w_short        = w_edge & ~w_rearm & (r_cnt < C_MIN);
    w_cand         = w_edge & ~w_rearm & ~w_short;
    w_full         = (r_fill == C_FULL);
    w_tmo          = ~w_edge & bus.i_sample_tick & (r_cnt == C_MAX - 16'd1);
    w_fill_nx_full = w_full | (r_fill == C_FULL_M1);
    w_evict        = r_hist[r_wr];
    w_start        = (r_state == S_IDLE) & r_pend & ~w_tmo;
  end

`ifdef BEAT_RATE_OUTLIER_EN
  logic [DIV_W-1:0] w_avg, w_lo, w_hi, w_cnt_ext;
  logic [7:0]       r_outlier_cnt;

  // Outlier window [avg/2, avg*3/2] around the current average interval
  always_comb begin
    w_avg     = r_sum >> C_LOG2_NB;
    w_lo      = w_avg >> 1;
    w_hi      = w_avg + (w_avg >> 1);
    w_cnt_ext = DIV_W'(r_cnt);
    w_outlier = w_cand & w_full & ((w_cnt_ext < w_lo) | (w_cnt_ext > w_hi));
  end

  // Saturating count of rejected intervals
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_outlier_cnt <= '0;
    else if (w_outlier && r_outlier_cnt != 8'hFF) r_outlier_cnt <= r_outlier_cnt + 8'd1;
  end

  assign bus.o_outlier_cnt = r_outlier_cnt;
`else
  assign w_outlier = 1'b0;
`endif

  assign w_accept = w_cand & ~w_outlier;

  // Interval counter, beat history ring, running sum and computation request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak_q <= 1'b0;
      r_cnt    <= '0;
      r_prior  <= 1'b0;
      r_pend   <= 1'b0;
      r_wr     <= '0;
      r_sum    <= '0;
      r_fill   <= '0;
      for (int i = 0; i < NBEATS; i++) r_hist[i] <= '0;
    end else begin
      r_peak_q <= bus.i_peak;
      // A tick coinciding with an edge is deliberately dropped
      if (w_rearm | w_cand)
        r_cnt <= '0;
      else if (~w_edge & bus.i_sample_tick & ~w_at_max)
        r_cnt <= r_cnt + 16'd1;

      if (w_rearm) r_prior <= 1'b1;

      if (w_tmo) begin
        r_prior <= 1'b0;
        r_wr    <= '0;
        r_sum   <= '0;
        r_fill  <= '0;
        for (int i = 0; i < NBEATS; i++) r_hist[i] <= '0;
      end else if (w_accept) begin
        r_hist[r_wr] <= r_cnt;
        r_wr         <= r_wr + 1'b1;
        // Evicted slot is zero while the ring is still filling
        r_sum        <= r_sum + DIV_W'(r_cnt) - DIV_W'(w_evict);
        if (!w_full) r_fill <= r_fill + 1'b1;
      end

      if (w_tmo)                          r_pend <= 1'b0;
      else if (w_accept & w_fill_nx_full) r_pend <= 1'b1;
      else if (w_start)                   r_pend <= 1'b0;
    end
  end

  // Restoring-divide step and double-dabble step
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[DIV_W-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_den});
    w_sub      = w_rem_sh[DIV_W-1:0] - r_den;
    w_rem_nx   = w_ge ? w_sub : w_rem_sh[DIV_W-1:0];
    w_quo_nx   = {r_quo[DIV_W-2:0], w_ge};
    w_q_sat    = (|w_quo_nx[DIV_W-1:8]) ? 8'hFF : w_quo_nx[7:0];
    w_adj      = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    w_div_last = (r_step == C_STEP_W'(DIV_W - 1));
    w_bcd_last = (r_step == C_STEP_W'(7));
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state; a timeout aborts any computation in flight
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pend)     w_next = S_DIV;
      S_DIV:   if (w_div_last) w_next = S_BCD;
      S_BCD:   if (w_bcd_last) w_next = S_OUT;
      S_OUT:                   w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_IDLE;
  end

  // Divider and BCD converter datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_step <= '0;
      r_q    <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_rem  <= '0;
          r_quo  <= C_DIVIDEND;
          r_den  <= r_sum;
          r_step <= '0;
        end
        S_DIV: begin
          r_rem  <= w_rem_nx;
          r_quo  <= w_quo_nx;
          r_step <= r_step + 1'b1;
          if (w_div_last) begin
            r_q    <= w_q_sat;
            r_bin  <= w_q_sat;
            r_bcd  <= '0;
            r_step <= '0;
          end
        end
        S_BCD: begin
          r_bcd  <= {w_adj[10:0], r_bin[7]};
          r_bin  <= {r_bin[6:0], 1'b0};
          r_step <= r_step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result outputs: refreshed on completion or loss of signal, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.o_bpm      <= '0;
      bus.o_bcd_hund <= '0;
      bus.o_bcd_tens <= '0;
      bus.o_bcd_ones <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_update   <= 1'b0;
      bus.o_timeout  <= 1'b1;
    end else begin
      bus.o_update <= 1'b0;
      if (w_tmo) begin
        bus.o_bpm      <= '0;
        bus.o_bcd_hund <= '0;
        bus.o_bcd_tens <= '0;
        bus.o_bcd_ones <= '0;
        bus.o_valid    <= 1'b0;
        bus.o_update   <= 1'b1;
        bus.o_timeout  <= 1'b1;
      end else begin
        if (r_state == S_OUT) begin
          bus.o_bpm      <= r_q;
          bus.o_bcd_hund <= r_bcd[11:8];
          bus.o_bcd_tens <= r_bcd[7:4];
          bus.o_bcd_ones <= r_bcd[3:0];
          bus.o_valid    <= 1'b1;
          bus.o_update   <= 1'b1;
        end
        if (w_rearm) bus.o_timeout <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beat_rate_calc.sv
// ============================================================================
// Module      : tb_beat_rate_calc
// Description : Scoreboard bench for beat_rate_calc. Two instances (default
//               refractory limit and MIN_INTERVAL=100) share a random tick
//               stream; a beat-level reference model predicts every update.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_beat_rate_calc;
  localparam int DIV_W = 24;
  localparam int NB    = 4;
  localparam int MAXI  = 3000;
  localparam int LAT   = DIV_W + 10;
  localparam int DIVIDEND = 60 * 1000 * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  beat_rate_calc_if bif0();
  beat_rate_calc_if bif1();

  beat_rate_calc #(.MIN_INTERVAL(250)) u_dut0 (.clk(clk), .reset(rst0), .bus(bif0.slave));
  beat_rate_calc #(.MIN_INTERVAL(100)) u_dut1 (.clk(clk), .reset(rst1), .bus(bif1.slave));

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  typedef struct {int k; longint cyc; int bpm; bit valid; bit tmo;} exp_t;
  exp_t exp_q[$];

  // Beat-level reference model, one slot per instance
  int m_since[2];
  bit m_prior[2];
  bit m_tmo[2];
  int m_hist[2][NB];
  int m_n[2];
  int m_bpm[2];
  bit m_valid[2];
  int m_ocnt[2];
  bit m_prev_pk[2];

  function automatic int min_of(input int k);
    return (k == 0) ? 250 : 100;
  endfunction

  function automatic bit has_exp(input int k);
    foreach (exp_q[i]) if (exp_q[i].k == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset(input int k);
    m_since[k] = 0; m_prior[k] = 0; m_tmo[k] = 1; m_n[k] = 0;
    m_bpm[k] = 0; m_valid[k] = 0; m_ocnt[k] = 0; m_prev_pk[k] = 0;
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].k == k) exp_q.delete(i);
  endfunction

  // Advance one clock of instance k; c is the clock edge that samples the inputs
  function automatic void model_step(input int k, input bit tick, input bit pk, input longint c);
    bit edge_ok = pk && !m_prev_pk[k];
    m_prev_pk[k] = pk;
    if (edge_ok) begin
      if (m_since[k] == MAXI || !m_prior[k]) begin
        m_prior[k] = 1; m_since[k] = 0; m_tmo[k] = 0;
      end else if (m_since[k] >= min_of(k)) begin
        bit acc = 1;
        int sum = 0;
        exp_t e;
`ifdef BEAT_RATE_OUTLIER_EN
        if (m_n[k] == NB) begin
          int avg = 0;
          for (int i = 0; i < NB; i++) avg += m_hist[k][i];
          avg = avg / NB;
          if (m_since[k] < avg / 2 || m_since[k] > avg + avg / 2) begin
            acc = 0;
            if (m_ocnt[k] < 255) m_ocnt[k]++;
          end
        end
`endif
        if (acc) begin
          if (m_n[k] == NB) begin
            for (int i = 0; i < NB - 1; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][NB-1] = m_since[k];
          end else begin
            m_hist[k][m_n[k]] = m_since[k];
            m_n[k]++;
          end
          if (m_n[k] == NB) begin
            for (int i = 0; i < NB; i++) sum += m_hist[k][i];
            e.k = k; e.cyc = c + LAT; e.valid = 1; e.tmo = 0;
            e.bpm = (DIVIDEND / sum > 255) ? 255 : DIVIDEND / sum;
            exp_q.push_back(e);
            m_bpm[k] = e.bpm; m_valid[k] = 1;
          end
        end
        m_since[k] = 0;
      end
    end else if (tick && m_since[k] < MAXI) begin
      m_since[k]++;
      if (m_since[k] == MAXI) begin
        exp_t e;
        m_prior[k] = 0; m_n[k] = 0; m_tmo[k] = 1; m_bpm[k] = 0; m_valid[k] = 0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].k == k && exp_q[i].cyc > c) exp_q.delete(i);
        e.k = k; e.cyc = c; e.bpm = 0; e.valid = 0; e.tmo = 1;
        exp_q.push_back(e);
      end
    end
  endfunction

  // Drive one clock of stimulus and tell the model what the next edge samples
  task automatic cyc_step(input bit p0, input bit p1);
    bit t;
    @(negedge clk);
    t = ($urandom_range(0, 3) != 0);
    bif0.i_sample_tick = t; bif1.i_sample_tick = t;
    bif0.i_peak = p0;       bif1.i_peak = p1;
    if (!rst0) model_step(0, t, p0, cyc + 1);
    if (!rst1) model_step(1, t, p1, cyc + 1);
  endtask

  // Wait until instance k has seen 'target' ticks since its last beat, then pulse peak
  task automatic beat(input int k, input int target);
    int guard = 0;
    while (m_since[k] < target && guard < 20000) begin
      cyc_step(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL beat_wait k=%0d since=%0d required=%0d", k, m_since[k], target);
    end
    repeat (2) cyc_step(k == 0, k == 1);
    cyc_step(1'b0, 1'b0);
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while (has_exp(k) && guard < 200) begin
      cyc_step(1'b0, 1'b0);
      guard++;
    end
    if (has_exp(k)) begin
      n_vec++; n_err++;
      $display("FAIL drain k=%0d: expected update never arrived", k);
    end
  endtask

  task automatic check_lvl(input int k, input string name);
    logic [7:0] bpm;
    logic [3:0] h, t, o;
    logic       v, tm;
    int         eb;
    bit         bad;
    if (k == 0) begin
      bpm = bif0.o_bpm; h = bif0.o_bcd_hund; t = bif0.o_bcd_tens; o = bif0.o_bcd_ones;
      v = bif0.o_valid; tm = bif0.o_timeout;
    end else begin
      bpm = bif1.o_bpm; h = bif1.o_bcd_hund; t = bif1.o_bcd_tens; o = bif1.o_bcd_ones;
      v = bif1.o_valid; tm = bif1.o_timeout;
    end
    eb = m_bpm[k];
    n_vec++;
    bad = (int'(bpm) != eb) || (int'(h) != eb / 100) || (int'(t) != (eb / 10) % 10) ||
          (int'(o) != eb % 10) || (v != m_valid[k]) || (tm != m_tmo[k]);
    if (bad) begin
      n_err++;
      $display("FAIL %s k=%0d got bpm=%0d bcd=%0d%0d%0d valid=%0d timeout=%0d want bpm=%0d valid=%0d timeout=%0d",
               name, k, bpm, h, t, o, v, tm, eb, m_valid[k], m_tmo[k]);
    end
`ifdef BEAT_RATE_OUTLIER_EN
    n_vec++;
    if (k == 0 && int'(bif0.o_outlier_cnt) != m_ocnt[0] || k == 1 && int'(bif1.o_outlier_cnt) != m_ocnt[1]) begin
      n_err++;
      $display("FAIL %s_outlier k=%0d got=%0d want=%0d", name, k,
               (k == 0) ? bif0.o_outlier_cnt : bif1.o_outlier_cnt, m_ocnt[k]);
    end
`endif
  endtask

  task automatic check_upd(input int k, input logic [7:0] bpm, input logic [3:0] h,
                           input logic [3:0] t, input logic [3:0] o, input logic v, input logic tm);
    int idx = -1;
    exp_t e;
    n_vec++;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].k == k) idx = i;
    if (idx < 0) begin
      n_err++;
      $display("FAIL unexpected_update k=%0d cyc=%0d bpm=%0d", k, cyc, bpm);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      if (e.cyc != cyc || int'(bpm) != e.bpm || int'(h) != e.bpm / 100 ||
          int'(t) != (e.bpm / 10) % 10 || int'(o) != e.bpm % 10 || v != e.valid || tm != e.tmo) begin
        n_err++;
        $display("FAIL update k=%0d got cyc=%0d bpm=%0d bcd=%0d%0d%0d valid=%0d timeout=%0d want cyc=%0d bpm=%0d valid=%0d timeout=%0d",
                 k, cyc, bpm, h, t, o, v, tm, e.cyc, e.bpm, e.valid, e.tmo);
      end
    end
  endtask

  // Monitor: count edges and score every update pulse against the queue
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bif0.o_update === 1'b1)
        check_upd(0, bif0.o_bpm, bif0.o_bcd_hund, bif0.o_bcd_tens, bif0.o_bcd_ones, bif0.o_valid, bif0.o_timeout);
      if (bif1.o_update === 1'b1)
        check_upd(1, bif1.o_bpm, bif1.o_bcd_hund, bif1.o_bcd_tens, bif1.o_bcd_ones, bif1.o_valid, bif1.o_timeout);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bif0.i_sample_tick = 0; bif0.i_peak = 0;
    bif1.i_sample_tick = 0; bif1.i_peak = 0;
    rst0 = 1; rst1 = 1;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    check_lvl(0, "reset"); check_lvl(1, "reset");
    rst0 = 0; rst1 = 0;

    // 60 BPM: one re-arm then four 1000-tick intervals
    beat(0, 20);
    repeat (4) beat(0, 1000);
    drain(0); check_lvl(0, "bpm60");

    // Rate climbs toward 120 BPM
    repeat (5) beat(0, 500);
    drain(0); check_lvl(0, "bpm120");

    // Refractory: early peak ignored, interval keeps counting
    beat(0, 200);
    beat(0, 1000);
    drain(0); check_lvl(0, "refractory");

    // Randomized intervals
    repeat (6) beat(0, $urandom_range(260, 1400));
    drain(0); check_lvl(0, "random");

    // Loss of signal, then re-arm and refill
    begin
      int guard = 0;
      while (!m_tmo[0] && guard < 10000) begin
        cyc_step(1'b0, 1'b0);
        guard++;
      end
    end
    drain(0); check_lvl(0, "timeout");
    beat(0, 10);
    check_lvl(0, "rearm");
    repeat (4) beat(0, 1000);
    drain(0); check_lvl(0, "refill");
`ifdef BEAT_RATE_OUTLIER_EN
    beat(0, 1600);
    repeat (40) cyc_step(1'b0, 1'b0);
    check_lvl(0, "outlier");
`endif

    // Short refractory instance: 200-tick intervals saturate at 255
    drain(1);
    beat(1, 5);
    repeat (4) beat(1, 200);
    drain(1); check_lvl(1, "sat255");

    // Reset while the divider is running
    beat(1, 200);
    repeat (5) cyc_step(1'b0, 1'b0);
    rst1 = 1;
    model_reset(1);
    repeat (3) cyc_step(1'b0, 1'b0);
    check_lvl(1, "reset_mid_div");
    rst1 = 0;
    repeat (60) cyc_step(1'b0, 1'b0);
    check_lvl(1, "post_reset");

    drain(0); drain(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
